// File: rtl/compute_lane_responder.sv
// Iterative round-function responder: accepts an operand, applies ROUNDS rounds of
// x <= rotl1(x) + ROUND_CONST, then holds the result as a level. Optional macro: COMPUTE_FAULT_INJECT_EN.
module compute_lane_responder #(
    parameter int unsigned WIDTH       = 64,
    parameter int unsigned ROUNDS      = 4,
    parameter logic [63:0] ROUND_CONST = 64'h9E37_79B9_7F4A_7C15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             comp_valid,
    output logic             comp_ready,
    input  logic [WIDTH-1:0] comp_data,
    output logic             comp_done,
    output logic [WIDTH-1:0] comp_out,
    output logic             overrun_err
`ifdef COMPUTE_FAULT_INJECT_EN
    ,
    input  logic             fault_arm,
    input  logic [WIDTH-1:0] fault_mask
`endif
);

    // state | meaning
    // IDLE  | no result held, ready for a command
    // BUSY  | rounds in progress, commands rejected (overrun)
    // DONE  | result held on comp_out, ready for a command
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam int unsigned      CW       = $clog2(ROUNDS + 1);
    localparam logic [WIDTH-1:0] RC       = WIDTH'(ROUND_CONST);
    localparam logic [CW-1:0]    CNT_INIT = CW'(ROUNDS);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             ovr_q, ovr_d;
    logic [WIDTH-1:0] round_val;

`ifdef COMPUTE_FAULT_INJECT_EN
    logic             arm_q, arm_d;
    logic [WIDTH-1:0] mask_q, mask_d;
`endif

    assign comp_ready  = (state_q != BUSY);
    assign comp_done   = (state_q == DONE);
    assign comp_out    = out_q;
    assign overrun_err = ovr_q;
    assign round_val   = {x_q[WIDTH-2:0], x_q[WIDTH-1]} + RC;

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        ovr_d   = ovr_q;
`ifdef COMPUTE_FAULT_INJECT_EN
        arm_d   = arm_q;
        mask_d  = mask_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (comp_valid) begin
                    x_d     = comp_data;
                    cnt_d   = CNT_INIT;
                    state_d = BUSY;
`ifdef COMPUTE_FAULT_INJECT_EN
                    arm_d   = fault_arm;
                    mask_d  = fault_mask;
`endif
                end
            end
            BUSY: begin
                x_d   = round_val;
                cnt_d = cnt_q - CW'(1);
                if (comp_valid) ovr_d = 1'b1;
                // Result is published on the same edge that applies the last round.
                if (cnt_q == CW'(1)) begin
                    state_d = DONE;
`ifdef COMPUTE_FAULT_INJECT_EN
                    out_d   = round_val ^ (arm_q ? mask_q : '0);
`else
                    out_d   = round_val;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            x_q     <= '0;
            cnt_q   <= '0;
            out_q   <= '0;
            ovr_q   <= 1'b0;
`ifdef COMPUTE_FAULT_INJECT_EN
            arm_q   <= 1'b0;
            mask_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            ovr_q   <= ovr_d;
`ifdef COMPUTE_FAULT_INJECT_EN
            arm_q   <= arm_d;
            mask_q  <= mask_d;
`endif
        end
    end

endmodule

// File: tb/tb_compute_lane_responder.sv
// Scoreboard bench for compute_lane_responder at WIDTH=8, ROUNDS=2, ROUND_CONST=8'h01.
// Fault-injection scenario is built only when COMPUTE_FAULT_INJECT_EN is defined.
module tb_compute_lane_responder;

    localparam int unsigned W  = 8;
    localparam int unsigned R  = 2;
    localparam logic [7:0]  RC = 8'h01;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         comp_valid = 1'b0;
    logic         comp_ready;
    logic [W-1:0] comp_data = '0;
    logic         comp_done;
    logic [W-1:0] comp_out;
    logic         overrun_err;
`ifdef COMPUTE_FAULT_INJECT_EN
    logic         fault_arm = 1'b0;
    logic [W-1:0] fault_mask = '0;
`endif

    logic [W-1:0] exp_q[$];
    int           checks = 0;
    int           errors = 0;
    bit           done_seen = 1'b0;

    compute_lane_responder #(
        .WIDTH      (W),
        .ROUNDS     (R),
        .ROUND_CONST(64'h01)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .comp_valid (comp_valid),
        .comp_ready (comp_ready),
        .comp_data  (comp_data),
        .comp_done  (comp_done),
        .comp_out   (comp_out),
        .overrun_err(overrun_err)
`ifdef COMPUTE_FAULT_INJECT_EN
        ,
        .fault_arm  (fault_arm),
        .fault_mask (fault_mask)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] model(input logic [W-1:0] d);
        logic [W-1:0] x;
        x = d;
        for (int i = 0; i < int'(R); i++) x = {x[W-2:0], x[W-1]} + RC;
        return x;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] d);
        logic [W-1:0] e;
        check_eq("ready_at_send", 32'(comp_ready), 32'd1);
        e = model(d);
`ifdef COMPUTE_FAULT_INJECT_EN
        if (fault_arm) e = e ^ fault_mask;
`endif
        exp_q.push_back(e);
        comp_valid = 1'b1;
        comp_data  = d;
        step();
        comp_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (!comp_done && n < budget) begin
            step();
            n++;
        end
        check_eq("done_wait", 32'(comp_done), 32'd1);
    endtask

    // Scoreboard monitor: pops one expectation per new result, samples on falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (comp_done && !done_seen) begin
                done_seen = 1'b1;
                if (exp_q.size() == 0) check_eq("unexpected_done", 32'(comp_done), 32'd0);
                else                   check_eq("result", 32'(comp_out), 32'(exp_q.pop_front()));
            end
            if (comp_valid && comp_ready && !rst) done_seen = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        step();
        step();
        rst = 1'b0;
        check_eq("rst_ready", 32'(comp_ready), 32'd1);
        check_eq("rst_done", 32'(comp_done), 32'd0);
        check_eq("rst_out", 32'(comp_out), 32'd0);
        check_eq("rst_ovr", 32'(overrun_err), 32'd0);

        // Basic latency: 0x80 -> two busy cycles -> 0x05 held
        send(8'h80);
        check_eq("busy1_ready", 32'(comp_ready), 32'd0);
        check_eq("busy1_done", 32'(comp_done), 32'd0);
        step();
        check_eq("busy2_ready", 32'(comp_ready), 32'd0);
        step();
        check_eq("done_level", 32'(comp_done), 32'd1);
        check_eq("done_ready", 32'(comp_ready), 32'd1);
        check_eq("done_out", 32'(comp_out), 32'h05);
        repeat (5) step();
        check_eq("hold_done", 32'(comp_done), 32'd1);
        check_eq("hold_out", 32'(comp_out), 32'h05);

        // Back-to-back: accept in first DONE cycle, no gap cycle
        send(8'h00);
        step();
        step();
        check_eq("b2b_first_out", 32'(comp_out), 32'h03);
        send(8'h80);
        check_eq("b2b_drop1", 32'(comp_done), 32'd0);
        step();
        check_eq("b2b_drop2", 32'(comp_done), 32'd0);
        step();
        check_eq("b2b_done", 32'(comp_done), 32'd1);
        check_eq("b2b_out", 32'(comp_out), 32'h05);

        // Overrun: strobe 0xFF in second busy cycle
        send(8'h80);
        step();
        comp_valid = 1'b1;
        comp_data  = 8'hFF;
        step();
        comp_valid = 1'b0;
        check_eq("ovr_set", 32'(overrun_err), 32'd1);
        check_eq("ovr_done", 32'(comp_done), 32'd1);
        check_eq("ovr_out", 32'(comp_out), 32'h05);
        repeat (3) step();
        check_eq("ovr_sticky", 32'(overrun_err), 32'd1);

        for (int i = 0; i < 6; i++) begin
            send(W'($urandom_range(0, 255)));
            wait_done(10);
        end
        check_eq("ovr_sticky_late", 32'(overrun_err), 32'd1);

        // Reset mid-BUSY with a coincident strobe
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_eq("ovr_cleared", 32'(overrun_err), 32'd0);
        send(8'h80);
        rst        = 1'b1;
        comp_valid = 1'b1;
        comp_data  = 8'hAA;
        exp_q.delete();
        step();
        rst        = 1'b0;
        comp_valid = 1'b0;
        check_eq("abort_done", 32'(comp_done), 32'd0);
        check_eq("abort_out", 32'(comp_out), 32'd0);
        check_eq("abort_ready", 32'(comp_ready), 32'd1);
        repeat (4) step();
        check_eq("abort_no_done", 32'(comp_done), 32'd0);
        check_eq("abort_no_ovr", 32'(overrun_err), 32'd0);

`ifdef COMPUTE_FAULT_INJECT_EN
        fault_arm  = 1'b1;
        fault_mask = 8'h10;
        send(8'h80);
        fault_arm  = 1'b0;
        fault_mask = 8'h00;
        wait_done(10);
        check_eq("fault_out", 32'(comp_out), 32'h15);
        send(8'h80);
        wait_done(10);
        check_eq("fault_clear_out", 32'(comp_out), 32'h05);
`endif

        step();
        check_eq("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/compute_lane_responder.md
COMPUTE_LANE_RESPONDER -- requirements
Module: compute_lane_responder

Interface
REQ-001 SHALL have parameter WIDTH, default 64: operand/result width in bits.
REQ-002 SHALL have parameter ROUNDS, default 4: number of iterative rounds, legal range 1..255.
REQ-003 SHALL have parameter ROUND_CONST, default 64'h9E37_79B9_7F4A_7C15, truncated to WIDTH: additive round constant.
REQ-004 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-006 SHALL have port comp_valid, input, 1: one-cycle command strobe from the requester.
REQ-007 SHALL have port comp_ready, output, 1: responder can accept a command this cycle.
REQ-008 SHALL have port comp_data, input, WIDTH: operand, sampled on accept.
REQ-009 SHALL have port comp_done, output, 1: result valid, held as a level.
REQ-010 SHALL have port comp_out, output, WIDTH: result, stable while comp_done=1.
REQ-011 SHALL have port overrun_err, output, 1: sticky flag, command strobed while busy.

Function
REQ-012 SHALL implement a state machine with three states: IDLE, BUSY and DONE.
REQ-013 SHALL drive comp_ready=1 in IDLE and DONE, and 0 in BUSY; comp_ready is combinational from state only.
REQ-014 SHALL accept when comp_valid && comp_ready at a clock edge: load x<=comp_data, load the round counter with ROUNDS, deassert comp_done, and go to BUSY.
REQ-015 SHALL, on each BUSY cycle, compute x <= rotl1(x) + ROUND_CONST mod 2^WIDTH and decrement the counter; rotl1 rotates left by one bit (MSB to LSB).
REQ-016 SHALL, on the edge that applies the final round, enter DONE with comp_done=1 and comp_out equal to the final x; latency is accept edge + ROUNDS edges.
REQ-017 SHALL hold comp_done=1 and comp_out constant in DONE until the next accept or reset, so that two lanes with equal latency present done in the same cycle.
REQ-018 SHALL, on an accept in DONE, drop comp_done on that edge and start the new command in BUSY; there is no gap cycle.
REQ-019 SHALL, when comp_valid=1 in BUSY, ignore the command, leave the computation undisturbed and set overrun_err=1 on the next edge.
REQ-020 SHALL keep overrun_err set until rst.
REQ-021 SHALL, when ROUNDS=1, use BUSY for exactly one cycle.
REQ-022 SHALL size the counter at $clog2(ROUNDS+1) bits; the counter never wraps.
REQ-023 SHALL keep comp_out at its last value outside DONE; consumers qualify it with comp_done only.

Reset
REQ-024 SHALL, while rst=1 at an edge, set state=IDLE, comp_done=0, comp_out=0, x=0, counter=0 and overrun_err=0.
REQ-025 SHALL, on rst asserted mid-BUSY or in DONE, abandon the operation and discard the result.
REQ-026 SHALL ignore a comp_valid coincident with rst=1.
REQ-027 SHALL assert comp_ready=1 in the first cycle after rst deasserts.

Configuration
REQ-028 SHALL, with macro COMPUTE_FAULT_INJECT_EN defined, add two ports: fault_arm (input, 1) and fault_mask (input, WIDTH).
REQ-029 SHALL, with COMPUTE_FAULT_INJECT_EN defined, latch fault_arm and fault_mask at accept, and XOR comp_out with the latched mask on entry to DONE when the latched arm=1.
REQ-030 SHALL, without COMPUTE_FAULT_INJECT_EN, omit both ports and add no injection logic; the result is always the pure round function.

Verification (WIDTH=8, ROUNDS=2, ROUND_CONST=8'h01)
REQ-031 SHALL cover: rst, then comp_valid with 8'h80 -> comp_ready=0 for 2 cycles, then comp_done=1, comp_out=8'h05, held indefinitely.
REQ-032 SHALL cover: 8'h00 accepted, then 8'h80 accepted in the first DONE cycle -> 8'h03 done, done low for 2 cycles, then 8'h05.
REQ-033 SHALL cover: comp_valid with 8'hFF in the second BUSY cycle of a 8'h80 run -> comp_out=8'h05 unaffected and overrun_err=1, remaining set until rst.
REQ-034 SHALL cover: rst pulse in the first BUSY cycle -> comp_done=0, comp_out=8'h00 and comp_ready=1 on the next cycle; no done appears.
REQ-035 SHALL cover: with COMPUTE_FAULT_INJECT_EN, fault_arm=1 and fault_mask=8'h10 at accept of 8'h80 -> comp_out=8'h15; the next command with fault_arm=0 -> unmasked result.
